// File: rtl/lfsr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen_if
//  Description : Control / data bundle for the lfsr_gen pseudo-random
//                generator.
//                  en       - advance the register by STEP shifts
//                  load     - capture seed_in this cycle (wins over en)
//                  seed_in  - run-time seed value
//                  data_out - current register state
//                  bit_out  - serial output, MSB of data_out
//                  wrap     - one-cycle strobe, an advance returned to SEED
//                  lock_err - one-cycle strobe, an all-zero state was replaced
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_gen_if #(
    parameter int WIDTH = 7
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] data_out;
    logic             bit_out;
    logic             wrap;
    logic             lock_err;

    // Controlling side (drives en/load/seed_in)
    modport master (
        output en, load, seed_in,
        input  data_out, bit_out, wrap, lock_err
    );

    // Generator side
    modport slave (
        input  en, load, seed_in,
        output data_out, bit_out, wrap, lock_err
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Parametrised Fibonacci LFSR. Shifts left, the XOR of the
//                tapped bits enters the LSB. Each enabled cycle applies STEP
//                shifts combinationally. Supports run-time seed loading,
//                all-zero lock-up recovery, a serial output and a strobe when
//                the sequence returns to SEED.
//  Ports       : clk       - rising-edge clock
//                rst       - asynchronous active-high reset
//                bus       - lfsr_gen_if.slave (en, load, seed_in, data_out,
//                            bit_out, wrap, lock_err)
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'h44,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               STEP  = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    lfsr_gen_if.slave   bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (WIDTH < 3 || WIDTH > 32) begin : g_width_chk
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (STEP < 1 || STEP > WIDTH) begin : g_step_chk
        $error("lfsr_gen: STEP must be in 1..WIDTH");
    end
    if (SEED == '0) begin : g_seed_chk
        $error("lfsr_gen: SEED must be non-zero");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_sreg_q;
    logic [WIDTH-1:0] w_sreg_d;
    logic             r_wrap_q;
    logic             w_wrap_d;
    logic             r_lock_err_q;
    logic             w_lock_err_d;
    logic [WIDTH-1:0] w_stepped;

    // One Fibonacci shift: MSB falls off, parity of tapped bits enters LSB.
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    // STEP shifts unrolled into a single combinational cone.
    always_comb begin
        w_stepped = r_sreg_q;
        for (int i = 0; i < STEP; i++) begin
            w_stepped = f_shift(w_stepped);
        end
    end

    // Next-state selection: load beats en beats hold. Both strobes default
    // low so they only ever last one cycle unless re-triggered.
    always_comb begin
        w_sreg_d     = r_sreg_q;
        w_wrap_d     = 1'b0;
        w_lock_err_d = 1'b0;
        if (bus.load) begin
            if (bus.seed_in != '0) begin
                w_sreg_d = bus.seed_in;
            end else begin
                // A zero seed would lock the register; substitute SEED.
                w_sreg_d     = SEED;
                w_lock_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (r_sreg_q == '0) begin
                // Zero state (upset or degenerate taps): recover, no wrap.
                w_sreg_d     = SEED;
                w_lock_err_d = 1'b1;
            end else begin
                w_sreg_d = w_stepped;
                w_wrap_d = (w_stepped == SEED);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg_q     <= SEED;
            r_wrap_q     <= 1'b0;
            r_lock_err_q <= 1'b0;
        end else begin
            r_sreg_q     <= w_sreg_d;
            r_wrap_q     <= w_wrap_d;
            r_lock_err_q <= w_lock_err_d;
        end
    end

    assign bus.data_out = r_sreg_q;
    assign bus.bit_out  = r_sreg_q[WIDTH-1];
    assign bus.wrap     = r_wrap_q;
    assign bus.lock_err = r_lock_err_q;

endmodule
`default_nettype wire

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator. Successor to the fixed 7-bit LFSR used for random delays in the FSM labs.
- Width, tap polynomial, seed and steps-per-enable are set at elaboration.
- Adds run-time seed loading, all-zero lock-up recovery, multi-step advance, a serial output and a period-wrap strobe.
- Feeds random-delay counters and test-pattern logic.

Parameters:
- WIDTH, 7, shift register length in bits; legal range 3..32.
- TAPS, 7'h44, feedback mask of WIDTH bits. TAPS[i]=1 XORs sreg[i] (0-indexed) into the feedback bit. The default is x^7+x^3+1.
- SEED, 1, reset and recovery value of WIDTH bits; must be non-zero (elaboration error otherwise).
- STEP, 1, number of LFSR shifts applied per enabled cycle; legal range 1..WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance the register by STEP shifts this cycle.
- load  input  1  load seed_in this cycle.
- seed_in  input  WIDTH  value captured when load=1.
- data_out  output  WIDTH  current register state.
- bit_out  output  1  serial output, combinational, equal to data_out[WIDTH-1].
- wrap  output  1  registered one-cycle strobe: an advance has just returned the state to SEED.
- lock_err  output  1  registered one-cycle strobe: an all-zero state was replaced by SEED.

Behaviour:
- Reset, asynchronous and active-high: sreg=SEED, wrap=0, lock_err=0. Outputs are valid immediately on reset assertion.
- Single shift function f(s) = {s[WIDTH-2:0], ^(s & TAPS)}: shift left, MSB dropped, feedback enters the LSB.
- Advance computes f applied STEP times, combinationally, in a single cycle.
- Priority on each rising edge when rst=0: load > en > hold.
- load=1, seed_in != 0:
  - sreg=seed_in; en is ignored.
  - wrap=0, lock_err=0 next cycle.
- load=1, seed_in == 0:
  - sreg=SEED.
  - lock_err=1 for exactly one cycle.
- load=0, en=1, sreg != 0: sreg = f^STEP(sreg).
- load=0, en=1, sreg == 0 (only possible via SEU or illegal TAPS):
  - sreg=SEED instead of advancing.
  - lock_err=1 for one cycle.
- load=0, en=0: sreg holds. Both strobes are 0 next cycle.
- wrap:
  - Set to 1 in the same cycle data_out becomes SEED, and only as the result of an en advance.
  - Never set by reset, load or lock-up recovery.
  - Cleared the following cycle unless a further advance again yields SEED.
- With maximal TAPS and STEP=1, wrap fires every 2^WIDTH-1 enabled cycles.
- With STEP>1, wrap fires only when the stepped sequence lands exactly on SEED.
- Latency: data_out, wrap and lock_err all reflect an edge's inputs one cycle after that edge; there is no extra pipeline stage.
- Reset asserted mid-operation overrides everything immediately; a pending load or en is discarded.
- en held high continuously advances every cycle with no bubbles.

Test Plan:
- Default params, rst pulse -> data_out=7'h01, wrap=0, lock_err=0, bit_out=0.
- Default params, en=1 for 7 cycles after reset -> data_out sequence 02,04,09,12,24,49,13.
- Default params, en=1 for 127 cycles after reset -> data_out=7'h01 and wrap=1 only in that cycle; no wrap pulse in the first 126 cycles.
- load=1, seed_in=7'h00 -> data_out=7'h01, lock_err=1 for one cycle. Then load=1 with en=1 and seed_in=7'h55 -> data_out=7'h55 (load wins), wrap=0.
- Mid-run at data_out=7'h24, assert rst between clock edges -> data_out=7'h01 immediately. en=0 for 5 cycles -> data_out holds.
- STEP=7, otherwise default params, one en cycle after reset -> data_out=7'h13. WIDTH=4, TAPS=4'h9, SEED=1: en 15 cycles -> back to 4'h1 with wrap=1.
